// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants for the VGA video path.
//  - Default horizontal/vertical timing (display, front porch, sync, back porch).
//  - span_total(): derives a line/frame total from its four segments.
//  - coord_t: the 10-bit screen coordinate carried on pixel_x/pixel_y.
//  - Screen-edge limits used by the downstream pixel generator.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int span_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = span_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  // Last visible column/row, used by the pixel generator for its screen edges.
  localparam int X_EDGE_MAX = H_DISPLAY_DEF - 1;
  localparam int Y_EDGE_MAX = V_DISPLAY_DEF - 1;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the VGA sync generator to its consumers.
//  p_tick       pixel enable, one system clock per pixel period
//  pixel_x/y    current pixel coordinate
//  video_on     current pixel is inside the visible area
//  hsync/vsync  sync levels for the connector
//  frame_start  one-clock pulse when the frame restarts at (0,0)
// master: the sync generator drives; slave: pixel generator / observer.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
  );

  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
  );

endinterface

// File: rtl/vga_tick_div.sv
// Pixel-rate enable generator.
//  clk     in  system clock
//  rst     in  synchronous active-high reset
//  p_tick  out high for one clk in every CLK_DIV clks
// div_cnt runs 0..CLK_DIV-1; p_tick is decoded from the registered count,
// so the first tick after reset lands on clk CLK_DIV-1.
module vga_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int  CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam bit  ONE_TO_ONE = (CLK_DIV == 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_tick_div: CLK_DIV must be in 1..16");
  end

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == CNT_LAST) div_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  // With a 1:1 divider the count never leaves zero, so the decode alone
  // would tick during reset; masking with rst keeps p_tick low there.
  assign p_tick = (div_cnt_q == CNT_LAST) & ~(ONE_TO_ONE & rst);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator (640x480@60 Hz by default).
//  clk  in   system clock (100 MHz)
//  rst  in   synchronous active-high reset
//  vga  master modport: p_tick, pixel_x, pixel_y, video_on, hsync,
//       vsync, frame_start
// Counters advance on p_tick. hsync/vsync/video_on/frame_start are
// registered from the next counter values, so they change on the same edge
// as pixel_x/pixel_y with no skew.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL  = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_FIRST = H_DISPLAY + H_FRONT;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_DISPLAY + V_FRONT;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam bit SYNC_IDLE = !SYNC_POL;
  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > COORD_MAX) begin : g_h_too_wide
    $error("vga_sync_gen: H_TOTAL exceeds the 10-bit pixel_x range");
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_too_wide
    $error("vga_sync_gen: V_TOTAL exceeds the 10-bit pixel_y range");
  end

  logic p_tick;

  vga_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .p_tick (p_tick)
  );

  coord_t pixel_x_q, pixel_x_d;
  coord_t pixel_y_q, pixel_y_d;
  logic   video_on_q, video_on_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   frame_start_q, frame_start_d;

  always_comb begin
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_start_d = 1'b0;
    if (p_tick) begin
      if (pixel_x_q == X_LAST) begin
        pixel_x_d = '0;
        if (pixel_y_q == Y_LAST) begin
          pixel_y_d     = '0;
          frame_start_d = 1'b1;
        end else begin
          pixel_y_d = pixel_y_q + 1'b1;
        end
      end else begin
        pixel_x_d = pixel_x_q + 1'b1;
      end
    end
    // Decode from the next position so outputs line up with the counters.
    video_on_d = (int'(pixel_x_d) < H_DISPLAY) && (int'(pixel_y_d) < V_DISPLAY);
    hsync_d = ((int'(pixel_x_d) >= HS_FIRST) && (int'(pixel_x_d) <= HS_LAST)) ? SYNC_POL : SYNC_IDLE;
    vsync_d = ((int'(pixel_y_d) >= VS_FIRST) && (int'(pixel_y_d) <= VS_LAST)) ? SYNC_POL : SYNC_IDLE;
  end

  // Reset values are the decode of position (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b1;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.p_tick      = p_tick;
  assign vga.pixel_x     = pixel_x_q;
  assign vga.pixel_y     = pixel_y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Four builds share one clock:
//  0: default 640x480, CLK_DIV=4
//  1: small raster (15x11), CLK_DIV=1, active-low sync
//  2: small raster (9x7),   CLK_DIV=3, active-high sync
//  3: default 640x480, CLK_DIV=1
// The reference derives every output from the clock count since reset
// release: pixel index = n / CLK_DIV, then x/y by division by the totals.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v = 4'hF;
  int checks = 0;
  int errors = 0;
  longint n = 0;

  vga_sync_gen_if if0 ();
  vga_sync_gen_if if1 ();
  vga_sync_gen_if if2 ();
  vga_sync_gen_if if3 ();

  vga_sync_gen u_dut0 (.clk(clk), .rst(rst_v[0]), .vga(if0));

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
  ) u_dut1 (.clk(clk), .rst(rst_v[1]), .vga(if1));

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_POL(1'b1)
  ) u_dut2 (.clk(clk), .rst(rst_v[2]), .vga(if2));

  vga_sync_gen #(.CLK_DIV(1)) u_dut3 (.clk(clk), .rst(rst_v[3]), .vga(if3));

  snap_t obs [4];
  assign obs[0] = {if0.p_tick, if0.pixel_x, if0.pixel_y, if0.video_on, if0.hsync, if0.vsync, if0.frame_start};
  assign obs[1] = {if1.p_tick, if1.pixel_x, if1.pixel_y, if1.video_on, if1.hsync, if1.vsync, if1.frame_start};
  assign obs[2] = {if2.p_tick, if2.pixel_x, if2.pixel_y, if2.video_on, if2.hsync, if2.vsync, if2.frame_start};
  assign obs[3] = {if3.p_tick, if3.pixel_x, if3.pixel_y, if3.video_on, if3.hsync, if3.vsync, if3.frame_start};

  // Expected outputs of build w on clk n after reset release.
  function automatic snap_t model(input int w, input longint t);
    int d, hd, hf, hs, hb, vd, vf, vs, vb;
    bit pol;
    longint p, ht, vt;
    int x, y;
    snap_t e;
    case (w)
      1:       begin d = 1; hd = 8;   hf = 2;  hs = 3;  hb = 2;  vd = 6;   vf = 1;  vs = 2; vb = 2;  pol = 1'b0; end
      2:       begin d = 3; hd = 5;   hf = 1;  hs = 2;  hb = 1;  vd = 3;   vf = 1;  vs = 1; vb = 2;  pol = 1'b1; end
      3:       begin d = 1; hd = 640; hf = 16; hs = 96; hb = 48; vd = 480; vf = 10; vs = 2; vb = 33; pol = 1'b0; end
      default: begin d = 4; hd = 640; hf = 16; hs = 96; hb = 48; vd = 480; vf = 10; vs = 2; vb = 33; pol = 1'b0; end
    endcase
    ht = longint'(hd + hf + hs + hb);
    vt = longint'(vd + vf + vs + vb);
    p  = t / d;
    x  = int'(p % ht);
    y  = int'((p / ht) % vt);
    e.p_tick      = ((t + 1) % d) == 0;
    e.x           = 10'(x);
    e.y           = 10'(y);
    e.video_on    = (x < hd) && (y < vd);
    e.hsync       = (x >= hd + hf && x < hd + hf + hs) ? pol : !pol;
    e.vsync       = (y >= vd + vf && y < vd + vf + vs) ? pol : !pol;
    e.frame_start = (p > 0) && (p % (ht * vt) == 0) && (t % d == 0);
    return e;
  endfunction

  // Holds build w in reset for k edges, checks the reset state, releases.
  task automatic test_reset(input int w, input int k);
    snap_t e;
    rst_v[w] = 1'b1;
    repeat (k) @(posedge clk);
    #1;
    e = model(w, 0);
    e.p_tick = 1'b0;
    checks++;
    if (obs[w] !== e) begin
      errors++;
      $display("FAIL reset_state dut%0d got=%h exp=%h", w, obs[w], e);
    end
    rst_v[w] = 1'b0;
    #1;
    n = 0;
  endtask

  task automatic test_tick_release();
    snap_t e;
    int first_tick;
    test_reset(0, 3);
    first_tick = -1;
    for (int i = 0; i < 12; i++) begin
      e = model(0, n);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL tick_release n=%0d got=%h exp=%h", n, obs[0], e);
      end
      if (obs[0].p_tick && first_tick < 0) first_tick = i;
      if (i == 4) begin
        checks++;
        if (obs[0].x !== 10'd1) begin
          errors++;
          $display("FAIL x_at_clk4 got=%0d exp=1", obs[0].x);
        end
      end
      @(posedge clk); #2; n++;
    end
    checks++;
    if (first_tick != 3) begin
      errors++;
      $display("FAIL first_tick got=%0d exp=3", first_tick);
    end
  endtask

  task automatic test_horizontal();
    snap_t e;
    int hs_low, vid_low;
    test_reset(0, 2);
    hs_low = 0;
    vid_low = 0;
    for (int i = 0; i < 3200; i++) begin
      e = model(0, n);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL horizontal n=%0d got=%h exp=%h", n, obs[0], e);
      end
      if (obs[0].hsync === 1'b0) hs_low++;
      if (obs[0].video_on === 1'b0) vid_low++;
      @(posedge clk); #2; n++;
    end
    checks++;
    if (hs_low != 384) begin
      errors++;
      $display("FAIL hsync_low_clks got=%0d exp=384", hs_low);
    end
    checks++;
    if (vid_low != 640) begin
      errors++;
      $display("FAIL blank_clks got=%0d exp=640", vid_low);
    end
  endtask

  // Continues from the end of line 0 to the wrap (799,10) -> (0,11).
  task automatic test_line_wrap();
    snap_t e;
    while (n < 35200) begin
      e = model(0, n);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL line_run n=%0d got=%h exp=%h", n, obs[0], e);
      end
      if (n == 35199) begin
        checks++;
        if (obs[0].x !== 10'd799 || obs[0].y !== 10'd10) begin
          errors++;
          $display("FAIL before_wrap got=(%0d,%0d) exp=(799,10)", obs[0].x, obs[0].y);
        end
      end
      @(posedge clk); #2; n++;
    end
    checks++;
    if (obs[0].x !== 10'd0 || obs[0].y !== 10'd11 || obs[0].hsync !== 1'b1 || obs[0].video_on !== 1'b1) begin
      errors++;
      $display("FAIL after_wrap got=(%0d,%0d) hs=%b vid=%b exp=(0,11) hs=1 vid=1",
               obs[0].x, obs[0].y, obs[0].hsync, obs[0].video_on);
    end
  endtask

  task automatic test_mid_reset();
    snap_t e;
    int extra;
    extra = $urandom_range(1, 4000);
    for (int i = 0; i < extra; i++) begin
      @(posedge clk); #2; n++;
    end
    test_reset(0, 1);
    for (int i = 0; i < 40; i++) begin
      e = model(0, n);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL after_mid_reset n=%0d got=%h exp=%h", n, obs[0], e);
      end
      @(posedge clk); #2; n++;
    end
  endtask

  task automatic test_clkdiv1();
    snap_t e;
    test_reset(3, 2);
    for (int i = 0; i < 1700; i++) begin
      e = model(3, n);
      checks++;
      if (obs[3] !== e) begin
        errors++;
        $display("FAIL div1_run n=%0d got=%h exp=%h", n, obs[3], e);
      end
      if (n == 800) begin
        checks++;
        if (obs[3].x !== 10'd0 || obs[3].y !== 10'd1) begin
          errors++;
          $display("FAIL div1_line_len got=(%0d,%0d) exp=(0,1)", obs[3].x, obs[3].y);
        end
      end
      @(posedge clk); #2; n++;
    end
  endtask

  task automatic test_frame();
    snap_t e;
    int starts, vs_low;
    test_reset(1, 2);
    starts = 0;
    vs_low = 0;
    for (int i = 0; i < 500; i++) begin
      e = model(1, n);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL frame_run n=%0d got=%h exp=%h", n, obs[1], e);
      end
      if (obs[1].frame_start === 1'b1) starts++;
      if (obs[1].vsync === 1'b0) vs_low++;
      @(posedge clk); #2; n++;
    end
    checks++;
    if (starts != 3) begin
      errors++;
      $display("FAIL frame_start_count got=%0d exp=3", starts);
    end
    checks++;
    if (vs_low != 90) begin
      errors++;
      $display("FAIL vsync_low_clks got=%0d exp=90", vs_low);
    end
  endtask

  task automatic test_polarity();
    snap_t e;
    int len;
    test_reset(2, 2);
    len = 189 * int'($urandom_range(2, 3)) + int'($urandom_range(0, 50));
    for (int i = 0; i < len; i++) begin
      e = model(2, n);
      checks++;
      if (obs[2] !== e) begin
        errors++;
        $display("FAIL polarity_run n=%0d got=%h exp=%h", n, obs[2], e);
      end
      @(posedge clk); #2; n++;
    end
  endtask

  task automatic test_back_to_back();
    snap_t e;
    int len;
    test_reset(1, 1);
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(0, 200));
      for (int i = 0; i < len; i++) begin
        e = model(1, n);
        checks++;
        if (obs[1] !== e) begin
          errors++;
          $display("FAIL b2b_run r=%0d n=%0d got=%h exp=%h", r, n, obs[1], e);
        end
        @(posedge clk); #2; n++;
      end
      test_reset(1, int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_v = 4'h0;
    test_tick_release();
    test_horizontal();
    test_line_wrap();
    test_mid_reset();
    test_clkdiv1();
    test_frame();
    test_polarity();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
